// File: rtl/ascon_hash_stream.sv
// ascon_hash_stream
//   Streaming Ascon-Hash engine. A message arrives as big-endian 64-bit
//   words over a valid/ready input. The engine pads the message, runs the
//   Ascon permutation iteratively (UNROLL rounds per clock), and returns the
//   digest as 64-bit words over a valid/ready output.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new hash (looked at only while idle)
//   in_valid   message word valid
//   in_ready   engine takes a message word this cycle (registered)
//   in_data    message word, byte 0 in bits 63:56
//   in_last    this is the final message word
//   in_bytes   valid bytes in the final word (0..8, larger values mean 8)
//   out_valid  digest word valid (held until out_ready)
//   out_ready  consumer takes the digest word
//   out_data   digest word (x0 of the state)
//   out_last   final digest word
//   busy       engine is not idle
module ascon_hash_stream #(
    parameter logic [63:0] IV        = 64'h00400c0000000100,
    parameter int          ROUNDS_A  = 12,
    parameter int          ROUNDS_B  = 12,
    parameter int          UNROLL    = 1,
    parameter int          OUT_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    input  logic [3:0]  in_bytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_ABSORB  = 3'd2,
        S_PERM_B  = 3'd3,
        S_PAD     = 3'd4,
        S_FINAL   = 3'd5,
        S_SQUEEZE = 3'd6
    } state_t;

    localparam logic [3:0]  STEP_C      = 4'(UNROLL);
    localparam logic [3:0]  RA_C        = 4'(ROUNDS_A);
    localparam logic [3:0]  RB_C        = 4'(ROUNDS_B);
    localparam logic [3:0]  LAST_WORD_C = 4'(OUT_WORDS - 1);
    localparam logic [63:0] PAD_WORD_C  = 64'h8000000000000000;

    // 64-bit rotate right
    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Round constant for round r of a p-round permutation: the last round of
    // any permutation always uses the same constant as round 11 of p=12.
    function automatic logic [7:0] round_const(input logic [3:0] p, input logic [3:0] r);
        logic [7:0] idx;
        idx = {4'h0, 4'd12 - p + r};
        return 8'hf0 - (idx * 8'h0f);
    endfunction

    // One Ascon round: constant addition, bitsliced S-box, linear diffusion
    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                      input logic [7:0]       c);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'h0, c};
        x3 = s[3];
        x4 = s[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    state_t           state_r;
    state_t           ret_r;        // where PERM_B goes when it finishes
    logic [4:0][63:0] x_r;          // x_r[i] holds state word x_i
    logic [3:0]       rnd_r;        // index of the first round done this cycle
    logic [3:0]       wcnt_r;       // digest word index being squeezed
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [63:0]      out_data_r;
    logic             busy_r;

    logic [3:0]       p_s;
    logic [4:0][63:0] perm_s;
    logic             perm_last_s;
    logic [3:0]       bytes_s;
    logic [63:0]      abs_word_s;

    // Round count of the permutation currently running
    always_comb begin
        if (state_r == S_PERM_B) begin
            p_s = RB_C;
        end else begin
            p_s = RA_C;
        end
    end

    // UNROLL rounds chained combinationally from the current state
    always_comb begin
        perm_s = x_r;
        for (int u = 0; u < UNROLL; u++) begin
            perm_s = ascon_round(perm_s, round_const(p_s, rnd_r + 4'(u)));
        end
    end

    assign perm_last_s = ((rnd_r + STEP_C) == p_s);
    assign bytes_s     = (in_bytes > 4'd8) ? 4'd8 : in_bytes;

    // Message word as absorbed: a short final word keeps its leading bytes,
    // gets 0x80 right after them and zeros beyond
    always_comb begin
        abs_word_s = in_data;
        if (in_last && (bytes_s != 4'd8)) begin
            for (int b = 0; b < 8; b++) begin
                if (4'(b) < bytes_s) begin
                    abs_word_s[63 - 8*b -: 8] = in_data[63 - 8*b -: 8];
                end else if (4'(b) == bytes_s) begin
                    abs_word_s[63 - 8*b -: 8] = 8'h80;
                end else begin
                    abs_word_s[63 - 8*b -: 8] = 8'h00;
                end
            end
        end else begin
            abs_word_s = in_data;
        end
    end

    // Control FSM, permutation state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            ret_r       <= S_IDLE;
            x_r         <= '0;
            rnd_r       <= 4'd0;
            wcnt_r      <= 4'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= 64'h0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        x_r     <= {64'h0, 64'h0, 64'h0, 64'h0, IV};
                        rnd_r   <= 4'd0;
                        busy_r  <= 1'b1;
                        state_r <= S_INIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_INIT: begin
                    x_r <= perm_s;
                    if (perm_last_s) begin
                        rnd_r      <= 4'd0;
                        in_ready_r <= 1'b1;
                        state_r    <= S_ABSORB;
                    end else begin
                        rnd_r <= rnd_r + STEP_C;
                    end
                end
                S_ABSORB: begin
                    if (in_valid && in_ready_r) begin
                        x_r[0]     <= x_r[0] ^ abs_word_s;
                        in_ready_r <= 1'b0;
                        rnd_r      <= 4'd0;
                        if (!in_last) begin
                            ret_r   <= S_ABSORB;
                            state_r <= S_PERM_B;
                        end else if (bytes_s == 4'd8) begin
                            // a full final block still needs its own padding block
                            ret_r   <= S_PAD;
                            state_r <= S_PERM_B;
                        end else begin
                            state_r <= S_FINAL;
                        end
                    end else begin
                        state_r <= S_ABSORB;
                    end
                end
                S_PERM_B: begin
                    x_r <= perm_s;
                    if (perm_last_s) begin
                        rnd_r <= 4'd0;
                        case (ret_r)
                            S_ABSORB: begin
                                in_ready_r <= 1'b1;
                                state_r    <= S_ABSORB;
                            end
                            S_PAD: begin
                                state_r <= S_PAD;
                            end
                            S_SQUEEZE: begin
                                out_valid_r <= 1'b1;
                                out_data_r  <= perm_s[0];
                                out_last_r  <= (wcnt_r == LAST_WORD_C);
                                state_r     <= S_SQUEEZE;
                            end
                            default: begin
                                busy_r  <= 1'b0;
                                state_r <= S_IDLE;
                            end
                        endcase
                    end else begin
                        rnd_r <= rnd_r + STEP_C;
                    end
                end
                S_PAD: begin
                    x_r[0]  <= x_r[0] ^ PAD_WORD_C;
                    rnd_r   <= 4'd0;
                    state_r <= S_FINAL;
                end
                S_FINAL: begin
                    x_r <= perm_s;
                    if (perm_last_s) begin
                        rnd_r       <= 4'd0;
                        wcnt_r      <= 4'd0;
                        out_valid_r <= 1'b1;
                        out_data_r  <= perm_s[0];
                        out_last_r  <= (LAST_WORD_C == 4'd0);
                        state_r     <= S_SQUEEZE;
                    end else begin
                        rnd_r <= rnd_r + STEP_C;
                    end
                end
                S_SQUEEZE: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (out_last_r) begin
                            out_data_r <= 64'h0;
                            busy_r     <= 1'b0;
                            state_r    <= S_IDLE;
                        end else begin
                            wcnt_r  <= wcnt_r + 4'd1;
                            rnd_r   <= 4'd0;
                            ret_r   <= S_SQUEEZE;
                            state_r <= S_PERM_B;
                        end
                    end else begin
                        state_r <= S_SQUEEZE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ascon_hash_stream.sv
// tb_ascon_hash_stream
//   Three engines (UNROLL = 1, 3, 12) driven one at a time from a vector
//   table. Expected digests come from a byte-oriented Ascon-Hash model using
//   the 5-bit S-box table; the empty-message vectors use the published digest.
module tb_ascon_hash_stream;

    localparam int NI    = 3;
    localparam int NV    = 8;
    localparam int MAXB  = 40;
    localparam int LIMIT = 200;
    localparam logic [63:0] IV_C = 64'h00400c0000000100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_a     [NI];
    logic        in_valid_a  [NI];
    logic        in_ready_a  [NI];
    logic [63:0] in_data_a   [NI];
    logic        in_last_a   [NI];
    logic [3:0]  in_bytes_a  [NI];
    logic        out_valid_a [NI];
    logic        out_ready_a [NI];
    logic [63:0] out_data_a  [NI];
    logic        out_last_a  [NI];
    logic        busy_a      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int U = (g == 0) ? 1 : ((g == 1) ? 3 : 12);
        ascon_hash_stream #(.UNROLL(U)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_a[g]),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g]),
            .in_last   (in_last_a[g]),
            .in_bytes  (in_bytes_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g]),
            .out_last  (out_last_a[g]),
            .busy      (busy_a[g])
        );
    end

    typedef struct {
        int              inst;
        int              len;
        bit              stall;
        bit              over;
        int              exp_init;
        int              exp_fin;
        logic [3:0][63:0] exp_dig;
    } vec_t;

    vec_t             tbl [NV];
    logic [7:0]       msg_t [NV][MAXB];
    logic [63:0]      got_dig [4];
    int               got_init;
    int               got_fin;
    logic [3:0][63:0] mdig;
    logic [3:0][63:0] kat;
    int               n_checks = 0;
    int               n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] sbox(input logic [4:0] v);
        logic [4:0] o;
        case (v)
            5'd0:  o = 5'h04;  5'd1:  o = 5'h0b;  5'd2:  o = 5'h1f;  5'd3:  o = 5'h14;
            5'd4:  o = 5'h1a;  5'd5:  o = 5'h15;  5'd6:  o = 5'h09;  5'd7:  o = 5'h02;
            5'd8:  o = 5'h1b;  5'd9:  o = 5'h05;  5'd10: o = 5'h08;  5'd11: o = 5'h12;
            5'd12: o = 5'h1d;  5'd13: o = 5'h03;  5'd14: o = 5'h06;  5'd15: o = 5'h1c;
            5'd16: o = 5'h1e;  5'd17: o = 5'h13;  5'd18: o = 5'h07;  5'd19: o = 5'h0e;
            5'd20: o = 5'h00;  5'd21: o = 5'h0d;  5'd22: o = 5'h11;  5'd23: o = 5'h18;
            5'd24: o = 5'h10;  5'd25: o = 5'h0c;  5'd26: o = 5'h01;  5'd27: o = 5'h19;
            5'd28: o = 5'h16;  5'd29: o = 5'h0a;  5'd30: o = 5'h0f;  5'd31: o = 5'h17;
            default: o = 5'h00;
        endcase
        return o;
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [4:0][63:0] mperm(input logic [4:0][63:0] si, input int p);
        logic [4:0][63:0] s;
        logic [4:0]       v;
        logic [4:0]       o;
        s = si;
        for (int r = 0; r < p; r++) begin
            s[2][7:0] = s[2][7:0] ^ 8'(240 - (12 - p + r) * 15);
            for (int b = 0; b < 64; b++) begin
                v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
                o = sbox(v);
                {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]} = o;
            end
            s[0] = s[0] ^ rot(s[0], 19) ^ rot(s[0], 28);
            s[1] = s[1] ^ rot(s[1], 61) ^ rot(s[1], 39);
            s[2] = s[2] ^ rot(s[2], 1)  ^ rot(s[2], 6);
            s[3] = s[3] ^ rot(s[3], 10) ^ rot(s[3], 17);
            s[4] = s[4] ^ rot(s[4], 7)  ^ rot(s[4], 41);
        end
        return s;
    endfunction

    // Byte-level Ascon-Hash: pad with 0x80 and zeros to whole blocks
    task automatic model_hash(input int vi, input int len);
        logic [4:0][63:0] s;
        logic [7:0]       q[$];
        logic [63:0]      blk;
        int               nblk;
        for (int i = 0; i < len; i++) q.push_back(msg_t[vi][i]);
        q.push_back(8'h80);
        while ((q.size() % 8) != 0) q.push_back(8'h00);
        s = '0;
        s[0] = IV_C;
        s = mperm(s, 12);
        nblk = q.size() / 8;
        for (int bi = 0; bi < nblk; bi++) begin
            blk = 64'h0;
            for (int b = 0; b < 8; b++) blk = {blk[55:0], q[8*bi + b]};
            s[0] = s[0] ^ blk;
            s = mperm(s, 12);
        end
        for (int w = 0; w < 4; w++) begin
            mdig[w] = s[0];
            if (w < 3) s = mperm(s, 12);
        end
    endtask

    function automatic int unroll_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 12);
    endfunction

    task automatic set_vec(input int v, input int inst, input int len, input bit stall,
                           input bit over);
        int n;
        n = 12 / unroll_of(inst);
        tbl[v].inst     = inst;
        tbl[v].len      = len;
        tbl[v].stall    = stall;
        tbl[v].over     = over;
        tbl[v].exp_init = n;
        tbl[v].exp_fin  = (len > 0 && (len % 8) == 0) ? 2*n + 1 : n;
        model_hash(v, len);
        tbl[v].exp_dig  = mdig;
    endtask

    // ---------------- driver ----------------
    task automatic run_hash(input int k, input int vi, input int len, input bit stall,
                            input bit over);
        int          nw, nb, cyc, saw, unstable;
        logic [63:0] w, held;
        got_init = -1;
        got_fin  = -1;
        for (int i = 0; i < 4; i++) got_dig[i] = 64'h0;
        @(negedge clk);
        start_a[k] = 1'b1;
        @(negedge clk);
        start_a[k] = 1'b0;
        chk("busy_after_start", 64'(busy_a[k]), 64'd1);
        for (cyc = 0; cyc < LIMIT; cyc++) begin
            if (in_ready_a[k]) break;
            @(negedge clk);
        end
        got_init = cyc;
        nw = (len == 0) ? 1 : (len + 7) / 8;
        for (int wi = 0; wi < nw; wi++) begin
            nb = (wi == nw - 1) ? len - 8*wi : 8;
            w  = {$urandom, $urandom};
            for (int b = 0; b < nb; b++) w[63 - 8*b -: 8] = msg_t[vi][8*wi + b];
            for (cyc = 0; cyc < LIMIT; cyc++) begin
                if (in_ready_a[k] && (!stall || $urandom_range(0, 2) != 0)) break;
                in_valid_a[k] = (stall && !in_ready_a[k]) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data_a[k]  = {$urandom, $urandom};
                in_last_a[k]  = 1'b1;
                in_bytes_a[k] = 4'd3;
                start_a[k]    = stall ? 1'($urandom_range(0, 3) == 0) : 1'b0;
                @(negedge clk);
            end
            start_a[k] = 1'b0;
            if (cyc >= LIMIT) begin
                chk("absorb_timeout", 64'd0, 64'd1);
                in_valid_a[k] = 1'b0;
                return;
            end
            in_valid_a[k] = 1'b1;
            in_data_a[k]  = w;
            in_last_a[k]  = (wi == nw - 1);
            in_bytes_a[k] = (over && nb == 8) ? 4'hf : 4'(nb);
            @(negedge clk);
            in_valid_a[k] = 1'b0;
            in_last_a[k]  = 1'b0;
        end
        saw = 0;
        for (cyc = 0; cyc < LIMIT; cyc++) begin
            if (out_valid_a[k]) break;
            if (in_ready_a[k]) saw++;
            in_valid_a[k] = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data_a[k]  = {$urandom, $urandom};
            @(negedge clk);
        end
        in_valid_a[k] = 1'b0;
        got_fin = cyc;
        chk("in_ready_low_after_last", 64'(saw), 64'd0);
        for (int wi = 0; wi < 4; wi++) begin
            for (cyc = 0; cyc < LIMIT; cyc++) begin
                if (out_valid_a[k]) break;
                out_ready_a[k] = stall ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
            out_ready_a[k] = 1'b0;
            if (cyc >= LIMIT) begin
                chk("squeeze_timeout", 64'd0, 64'd1);
                return;
            end
            held = out_data_a[k];
            chk("out_last", 64'(out_last_a[k]), (wi == 3) ? 64'd1 : 64'd0);
            if (stall) begin
                unstable = 0;
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    if (out_valid_a[k] !== 1'b1 || out_data_a[k] !== held) unstable++;
                end
                chk("stall_stable", 64'(unstable), 64'd0);
            end
            got_dig[wi]    = out_data_a[k];
            out_ready_a[k] = 1'b1;
            @(negedge clk);
            out_ready_a[k] = 1'b0;
        end
        chk("busy_done", 64'(busy_a[k]), 64'd0);
        chk("out_valid_done", 64'(out_valid_a[k]), 64'd0);
    endtask

    task automatic check_kat(input string tag);
        run_hash(0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk(tag, got_dig[i], kat[i]);
    endtask

    initial begin
        int cyc, bad;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start_a[k]     = 1'b0;
            in_valid_a[k]  = 1'b0;
            in_data_a[k]   = 64'h0;
            in_last_a[k]   = 1'b0;
            in_bytes_a[k]  = 4'd0;
            out_ready_a[k] = 1'b0;
        end
        kat[0] = 64'h7346bc14f036e87a;
        kat[1] = 64'he03d0997913088f5;
        kat[2] = 64'hf68411434b3cf8b5;
        kat[3] = 64'h4fa796a80d251f91;

        for (int v = 0; v < NV; v++)
            for (int i = 0; i < MAXB; i++) msg_t[v][i] = 8'($urandom);
        for (int i = 0; i < 17; i++) begin
            msg_t[3][i] = msg_t[2][i];
            msg_t[4][i] = msg_t[2][i];
        end
        set_vec(0, 0, 0,  1'b0, 1'b0);
        set_vec(1, 0, 8,  1'b0, 1'b0);
        set_vec(2, 0, 17, 1'b1, 1'b0);
        set_vec(3, 1, 17, 1'b0, 1'b0);
        set_vec(4, 2, 17, 1'b1, 1'b0);
        set_vec(5, 0, int'($urandom_range(1, MAXB)), 1'b1, 1'b0);
        set_vec(6, 1, 16, 1'b0, 1'b1);
        set_vec(7, 2, 0,  1'b1, 1'b0);
        tbl[0].exp_dig = kat;
        tbl[7].exp_dig = kat;

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_in_ready",  64'(in_ready_a[k]),  64'd0);
            chk("rst_out_valid", 64'(out_valid_a[k]), 64'd0);
            chk("rst_out_last",  64'(out_last_a[k]),  64'd0);
            chk("rst_out_data",  out_data_a[k],       64'd0);
            chk("rst_busy",      64'(busy_a[k]),      64'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            run_hash(tbl[v].inst, v, tbl[v].len, tbl[v].stall, tbl[v].over);
            chk($sformatf("v%0d_init_cycles", v), 64'(got_init), 64'(tbl[v].exp_init));
            chk($sformatf("v%0d_final_cycles", v), 64'(got_fin), 64'(tbl[v].exp_fin));
            for (int i = 0; i < 4; i++)
                chk($sformatf("v%0d_digest%0d", v, i), got_dig[i], tbl[v].exp_dig[i]);
        end

        // reset while absorbing
        @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        for (cyc = 0; cyc < LIMIT && !in_ready_a[0]; cyc++) @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = {$urandom, $urandom};
        in_last_a[0]  = 1'b0;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        for (cyc = 0; cyc < LIMIT && !in_ready_a[0]; cyc++) @(negedge clk);
        chk("absorb_reached", 64'(in_ready_a[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_absorb_in_ready", 64'(in_ready_a[0]), 64'd0);
        chk("rst_absorb_busy",     64'(busy_a[0]),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_kat("kat_after_absorb_reset");

        // reset while squeezing
        @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        for (cyc = 0; cyc < LIMIT && !in_ready_a[0]; cyc++) @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_last_a[0]  = 1'b1;
        in_bytes_a[0] = 4'd0;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        in_last_a[0]  = 1'b0;
        for (cyc = 0; cyc < LIMIT && !out_valid_a[0]; cyc++) @(negedge clk);
        chk("squeeze_reached", 64'(out_valid_a[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_squeeze_out_valid", 64'(out_valid_a[0]), 64'd0);
        chk("rst_squeeze_out_data",  out_data_a[0],       64'd0);
        chk("rst_squeeze_busy",      64'(busy_a[0]),      64'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        out_ready_a[0] = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_a[0] || busy_a[0]) bad++;
        end
        out_ready_a[0] = 1'b0;
        chk("no_output_after_reset", 64'(bad), 64'd0);
        check_kat("kat_after_squeeze_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
